// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: shared types and constants for the FP add/sub issue scheduler.
//   state_t  : arbitration FSM states (IDLE, WAIT)
//   MODE_*   : datapath mode encodings (1 = one double, 0 = two packed singles)
//   LANE*_*  : bit ranges of the two single-precision lanes in a 64-bit word
//   tag_t    : per-issue ownership tag carried alongside the adder pipeline
package fp_sched_pkg;

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic MODE_DBL = 1'b1;
   localparam logic MODE_SGL = 1'b0;

   localparam int LANE0_LO = 0;
   localparam int LANE0_HI = 31;
   localparam int LANE1_LO = 32;
   localparam int LANE1_HI = 63;

   typedef struct packed {
      logic own0;
      logic own1;
      logic dbl;
   } tag_t;

endpackage

// File: rtl/fp_sched_track.sv
// fp_sched_track: in-flight tag tracker and result-lane router for the FP add scheduler.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   issue_valid         an op enters the adder this cycle
//   issue_own0/own1     requester(s) owning the op (both set for a paired op)
//   issue_dbl           op is a double (full 64-bit result to the owner)
//   dp_result           adder result, valid LATENCY cycles after issue_valid
//   rsp0_valid/data     registered response to requester 0
//   rsp1_valid/data     registered response to requester 1
//   in_flight           any op still travelling through the adder
module fp_sched_track
   import fp_sched_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic        issue_own0,
   input  logic        issue_own1,
   input  logic        issue_dbl,
   input  logic [63:0] dp_result,
   output logic        rsp0_valid,
   output logic [63:0] rsp0_data,
   output logic        rsp1_valid,
   output logic [63:0] rsp1_data,
   output logic        in_flight
);

   // sh[LATENCY-1] lines up with dp_result of the op issued LATENCY cycles ago
   tag_t [LATENCY-1:0] sh;
   tag_t               head;

   assign head      = sh[LATENCY-1];
   assign in_flight = |sh;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sh         <= '0;
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
      end else begin
         sh[0] <= issue_valid ? tag_t'{issue_own0, issue_own1, issue_dbl} : tag_t'('0);
         for (int i = 1; i < LATENCY; i++) sh[i] <= sh[i-1];
         rsp0_valid <= head.own0;
         rsp1_valid <= head.own1;
         rsp0_data  <= !head.own0 ? '0 :
                       head.dbl ? dp_result : {32'b0, dp_result[LANE0_HI:LANE0_LO]};
         rsp1_data  <= !head.own1 ? '0 :
                       head.dbl ? dp_result : {32'b0, dp_result[LANE1_HI:LANE1_LO]};
      end

endmodule

// File: rtl/fp_add_lane_sched.sv
// fp_add_lane_sched: issue scheduler in front of the dual-mode FP add/sub datapath.
// Arbitrates two requesters, packs two singles into one dual-single issue, and
// routes each result lane back to its owner after the fixed adder latency.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   i_req{0,1}_valid/dbl/A/B         request (held until ready), 1 = double op
//   o_req{0,1}_ready                 combinational accept strobe
//   o_dp_valid/mode/A/B              registered issue to the datapath
//   i_dp_result                      datapath result, LATENCY cycles after o_dp_valid
//   o_rsp{0,1}_valid/data            per-requester response, no backpressure
//   o_busy                           waiting for a partner or any op in flight
module fp_add_lane_sched
   import fp_sched_pkg::*;
#(
   parameter int LATENCY   = 4,
   parameter int PAIR_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req0_valid,
   input  logic        i_req0_dbl,
   input  logic [63:0] i_req0_A,
   input  logic [63:0] i_req0_B,
   output logic        o_req0_ready,
   input  logic        i_req1_valid,
   input  logic        i_req1_dbl,
   input  logic [63:0] i_req1_A,
   input  logic [63:0] i_req1_B,
   output logic        o_req1_ready,
   output logic        o_dp_valid,
   output logic        o_dp_mode,
   output logic [63:0] o_dp_A,
   output logic [63:0] o_dp_B,
   input  logic [63:0] i_dp_result,
   output logic        o_rsp0_valid,
   output logic [63:0] o_rsp0_data,
   output logic        o_rsp1_valid,
   output logic [63:0] o_rsp1_data,
   output logic        o_busy
);

   localparam int CW = (PAIR_WAIT > 1) ? $clog2(PAIR_WAIT) + 1 : 1;

   state_t        state, state_nx;
   logic          rr, rr_nx;
   logic          wid, wid_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          go0, go1;
   logic          p_v, p_d, timeout;
   logic          iss_dbl;
   logic [63:0]   a_nx, b_nx;
   logic          own0_q, own1_q;
   logic          in_flight;

   // wid = which requester sits in WAIT; the partner is the other one
   assign p_v     = wid ? i_req0_valid : i_req1_valid;
   assign p_d     = wid ? i_req0_dbl   : i_req1_dbl;
   // the IDLE cycle that parked the single counts as wait cycle 0
   assign timeout = int'(cnt) >= PAIR_WAIT - 1;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         rr    <= 1'b0;
         wid   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         rr    <= rr_nx;
         wid   <= wid_nx;
         cnt   <= cnt_nx;
      end

   always_comb begin
      go0      = 1'b0;
      go1      = 1'b0;
      state_nx = state;
      rr_nx    = rr;
      wid_nx   = wid;
      cnt_nx   = cnt;
      if (state == IDLE) begin
         if (i_req0_valid && i_req1_valid) begin
            if (!i_req0_dbl && !i_req1_dbl) begin
               go0 = 1'b1;
               go1 = 1'b1;
            end else begin
               go0   = !rr;
               go1   = rr;
               rr_nx = !rr;
            end
         end else if (i_req0_valid || i_req1_valid) begin
            if ((i_req0_valid && i_req0_dbl) || (i_req1_valid && i_req1_dbl) || PAIR_WAIT == 0) begin
               go0 = i_req0_valid;
               go1 = i_req1_valid;
            end else begin
               state_nx = WAIT;
               wid_nx   = i_req1_valid;
               cnt_nx   = CW'(1);
            end
         end
      end else begin
         cnt_nx = cnt + 1'b1;
         if (p_v && !p_d) begin
            go0      = 1'b1;
            go1      = 1'b1;
            state_nx = IDLE;
         end else if (p_v || timeout) begin
            // a double partner is left for IDLE to take next cycle
            go0      = !wid;
            go1      = wid;
            state_nx = IDLE;
         end
      end
   end

   always_comb begin
      o_req0_ready = go0;
      o_req1_ready = go1;
      iss_dbl      = (go0 && !go1 && i_req0_dbl) || (go1 && !go0 && i_req1_dbl);
      a_nx = iss_dbl ? (go0 ? i_req0_A : i_req1_A) :
             {go1 ? i_req1_A[LANE0_HI:LANE0_LO] : 32'b0, go0 ? i_req0_A[LANE0_HI:LANE0_LO] : 32'b0};
      b_nx = iss_dbl ? (go0 ? i_req0_B : i_req1_B) :
             {go1 ? i_req1_B[LANE0_HI:LANE0_LO] : 32'b0, go0 ? i_req0_B[LANE0_HI:LANE0_LO] : 32'b0};
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         o_dp_valid <= 1'b0;
         o_dp_mode  <= MODE_SGL;
         o_dp_A     <= '0;
         o_dp_B     <= '0;
         own0_q     <= 1'b0;
         own1_q     <= 1'b0;
      end else begin
         o_dp_valid <= go0 || go1;
         o_dp_mode  <= iss_dbl ? MODE_DBL : MODE_SGL;
         o_dp_A     <= a_nx;
         o_dp_B     <= b_nx;
         own0_q     <= go0;
         own1_q     <= go1;
      end

   fp_sched_track #(.LATENCY(LATENCY)) u_track (
      .clk        (clk),
      .rst        (rst),
      .issue_valid(o_dp_valid),
      .issue_own0 (own0_q),
      .issue_own1 (own1_q),
      .issue_dbl  (o_dp_mode),
      .dp_result  (i_dp_result),
      .rsp0_valid (o_rsp0_valid),
      .rsp0_data  (o_rsp0_data),
      .rsp1_valid (o_rsp1_valid),
      .rsp1_data  (o_rsp1_data),
      .in_flight  (in_flight)
   );

   assign o_busy = (state == WAIT) || o_dp_valid || in_flight;

endmodule
